// File: rtl/alu_pkg.sv
// Shared widths, result-buffer state encoding and ALU32 mode constants.
package alu_pkg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned MODE_W = 4;

  // Result buffer occupancy
  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } buf_state_e;

  // ALU32 operation codes; unlisted codes produce zero
  localparam logic [MODE_W-1:0] ALU_PASSA = 4'd0;
  localparam logic [MODE_W-1:0] ALU_ADD   = 4'd1;
  localparam logic [MODE_W-1:0] ALU_SUB   = 4'd2;
  localparam logic [MODE_W-1:0] ALU_AND   = 4'd3;
  localparam logic [MODE_W-1:0] ALU_OR    = 4'd4;
  localparam logic [MODE_W-1:0] ALU_XOR   = 4'd5;
  localparam logic [MODE_W-1:0] ALU_SLL   = 4'd6;
  localparam logic [MODE_W-1:0] ALU_SRL   = 4'd7;
  localparam logic [MODE_W-1:0] ALU_SRA   = 4'd8;
  localparam logic [MODE_W-1:0] ALU_SLT   = 4'd9;
  localparam logic [MODE_W-1:0] ALU_SLTU  = 4'd10;

endpackage

// File: rtl/alu32.sv
// Purely combinational 32-bit ALU; arithmetic wraps modulo 2^32, no flags.
module alu32
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0]  a_i,
  input  logic [WIDTH-1:0]  b_i,
  input  logic [MODE_W-1:0] mode_i,
  output logic [WIDTH-1:0]  x_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  // Decode the mode into a single result
  always_comb begin
    x_o = '0;
    case (mode_i)
      ALU_PASSA: x_o = a_i;
      ALU_ADD:   x_o = a_i + b_i;
      ALU_SUB:   x_o = a_i - b_i;
      ALU_AND:   x_o = a_i & b_i;
      ALU_OR:    x_o = a_i | b_i;
      ALU_XOR:   x_o = a_i ^ b_i;
      ALU_SLL:   x_o = a_i << shamt;
      ALU_SRL:   x_o = a_i >> shamt;
      ALU_SRA:   x_o = $unsigned($signed(a_i) >>> shamt);
      ALU_SLT:   x_o = {{(WIDTH-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      ALU_SLTU:  x_o = {{(WIDTH-1){1'b0}}, a_i < b_i};
      default:   x_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU32 between two requesters, with a one-entry
// registered result buffer that refills in the same cycle it drains.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = alu_pkg::WIDTH,
  parameter int unsigned MODE_W = alu_pkg::MODE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [MODE_W-1:0] req0_mode,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [MODE_W-1:0] req1_mode,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [WIDTH-1:0]  rsp_x
);

  buf_state_e        state_q, state_d;
  logic              prio_q, prio_d;
  logic              id_q, id_d;
  logic [WIDTH-1:0]  x_q, x_d;

  logic [1:0]        grant;
  logic              can_accept;
  logic              accept;
  logic [WIDTH-1:0]  alu_a, alu_b, alu_x;
  logic [MODE_W-1:0] alu_mode;

  // Grant: a lone requester wins outright, contention goes to prio_q
  always_comb begin
    grant = req_valid;
    if (req_valid == 2'b11) begin
      grant = prio_q ? 2'b10 : 2'b01;
    end
  end

  // Gate with rst_n so ready is low for the whole reset assertion
  assign can_accept = (state_q == StEmpty) || rsp_ready;
  assign req_ready  = grant & {2{can_accept & rst_n}};
  assign accept     = |(req_valid & req_ready);

  // Operand mux; requester 0 is presented when idle and simply ignored
  always_comb begin
    alu_a    = req0_a;
    alu_b    = req0_b;
    alu_mode = req0_mode;
    if (grant[1]) begin
      alu_a    = req1_a;
      alu_b    = req1_b;
      alu_mode = req1_mode;
    end
  end

  alu32 u_alu32 (
    .a_i    (alu_a),
    .b_i    (alu_b),
    .mode_i (alu_mode),
    .x_o    (alu_x)
  );

  // Buffer FSM and priority next-state; drained entries keep stale payload
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    id_d    = id_q;
    x_d     = x_q;
    if (accept) begin
      state_d = StFull;
      x_d     = alu_x;
      id_d    = grant[1];
      prio_d  = ~grant[1];
    end else if ((state_q == StFull) && rsp_ready) begin
      state_d = StEmpty;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      prio_q  <= 1'b0;
      id_q    <= 1'b0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      id_q    <= id_d;
      x_q     <= x_d;
    end
  end

  assign rsp_valid = (state_q == StFull);
  assign rsp_id    = id_q;
  assign rsp_x     = x_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_mode, req1_mode;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_x;

  int checks;
  int failures;

  alu_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req0_mode (req0_mode),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req1_mode (req1_mode),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_x     (rsp_x)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    req0_a = 32'h1; req0_b = 32'h2; req0_mode = 4'd1;
    req1_a = 32'h5; req1_b = 32'h5; req1_mode = 4'd1;

    // Reset state, with a request pending to show ready is gated
    #2;
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp_id",    {63'd0, rsp_id},    64'd0);
    check("rst_rsp_x",     {32'd0, rsp_x},     64'd0);
    check("rst_req_ready", {62'd0, req_ready}, 64'd0);
    tick();
    rst_n = 1'b1;

    // Single op from requester 0: 1 + 2
    #1;
    check("single_ready", {62'd0, req_ready}, 64'd1);
    tick();
    req_valid = 2'b00;
    check("single_valid", {63'd0, rsp_valid}, 64'd1);
    check("single_id",    {63'd0, rsp_id},    64'd0);
    check("single_x",     {32'd0, rsp_x},     64'h3);
    tick();
    check("single_drain", {63'd0, rsp_valid}, 64'd0);

    // Contention from reset: grants alternate 0,1,0,1 with no bubbles
    do_reset();
    req0_a = 32'hA; req0_b = 32'h20;
    req_valid = 2'b11;
    #1;
    check("cont_ready0", {62'd0, req_ready}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) req_valid = 2'b00;
      check("cont_valid", {63'd0, rsp_valid}, 64'd1);
      check("cont_id", {63'd0, rsp_id}, (i % 2 == 0) ? 64'd0 : 64'd1);
      check("cont_x", {32'd0, rsp_x}, (i % 2 == 0) ? 64'h2A : 64'hA);
      if (i < 3) check("cont_ready", {62'd0, req_ready}, (i % 2 == 0) ? 64'd2 : 64'd1);
    end

    // Backpressure: buffer holds id 1 / 0xA, nothing accepted
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", {62'd0, req_ready}, 64'd0);
      check("bp_valid", {63'd0, rsp_valid}, 64'd1);
      check("bp_id",    {63'd0, rsp_id},    64'd1);
      check("bp_x",     {32'd0, rsp_x},     64'hA);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", {62'd0, req_ready}, 64'd1);
    tick();
    req_valid = 2'b00;
    check("bp_refill_valid", {63'd0, rsp_valid}, 64'd1);
    check("bp_refill_id",    {63'd0, rsp_id},    64'd0);
    check("bp_refill_x",     {32'd0, rsp_x},     64'h2A);
    tick();
    check("bp_drain", {63'd0, rsp_valid}, 64'd0);

    // Wrap-around: 0xFFFFFFFF + 1
    req0_a = 32'hFFFF_FFFF; req0_b = 32'h1;
    req_valid = 2'b01;
    tick();
    check("wrap_x",  {32'd0, rsp_x},  64'h0);
    check("wrap_id", {63'd0, rsp_id}, 64'd0);
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    check("refill1_x",  {32'd0, rsp_x},  64'hA);
    check("refill1_id", {63'd0, rsp_id}, 64'd1);

    // Asynchronous reset between edges while FULL
    req_valid = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", {63'd0, rsp_valid}, 64'd0);
    check("async_x",     {32'd0, rsp_x},     64'h0);
    check("async_id",    {63'd0, rsp_id},    64'd0);
    check("async_ready", {62'd0, req_ready}, 64'd0);
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    check("post_rst_ready", {62'd0, req_ready}, 64'd1);
    tick();
    req_valid = 2'b00;
    check("post_rst_id", {63'd0, rsp_id}, 64'd0);
    tick();

    // Lone requester 1 twice, then contention favours requester 0
    req0_a = 32'hA; req0_b = 32'h20;
    do_reset();
    req_valid = 2'b10;
    #1;
    check("lone_ready", {62'd0, req_ready}, 64'd2);
    tick();
    check("lone_id0", {63'd0, rsp_id}, 64'd1);
    tick();
    check("lone_id1", {63'd0, rsp_id}, 64'd1);
    check("lone_x",   {32'd0, rsp_x},  64'hA);
    req_valid = 2'b11;
    #1;
    check("fair_ready", {62'd0, req_ready}, 64'd1);
    tick();
    req_valid = 2'b00;
    check("fair_id", {63'd0, rsp_id}, 64'd0);
    check("fair_x",  {32'd0, rsp_x},  64'h2A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
